id_ex_stage: RTL
================

// Module: id_ex_stage
// PURPOSE
//   ID/EX pipeline stage of the RV32 core: registers one decoded instruction and drives the ALU operand/opcode inputs.
//   Resolves data hazards by forwarding from MEM/WB (or stalling), inserts bubbles, and honours downstream back-pressure and flush.
//   Sits between decode and the combinational ALU; its ex_* outputs feed the EX/MEM register.
// PARAMETERS
//   DATA_WIDTH     32  operand/result width
//   OPCODE_LENGTH  4   ALU Operation width
//   REG_ADDR_W     5   register index width
// PORTS
//   clk           in   1   single core clock; all state updates on rising edge
//   rst_n         in   1   asynchronous, active-low reset
//   dec_valid     in   1   decode presents an instruction
//   dec_ready     out  1   stage accepts it this cycle
//   dec_rs1_data  in   DW  rs1 value from regfile;   dec_rs2_data in DW  rs2 value
//   dec_imm       in   DW  sign-extended immediate
//   dec_rs1/rs2/rd in  RAW register indices
//   dec_alu_op    in   OL  ALU operation code
//   dec_alu_src   in   1   1: SrcB=imm, 0: SrcB=rs2
//   dec_reg_write, dec_mem_read, dec_mem_write  in 1 each  control bits
//   flush         in   1   kill EX contents and the decode handshake (taken branch)
//   ex_ready      in   1   EX/MEM register can accept
//   mem_reg_write in 1; mem_rd in RAW; mem_result in DW   MEM-stage writer
//   wb_reg_write  in 1; wb_rd  in RAW; wb_result  in DW   WB-stage writer
//   SrcA, SrcB    out  DW  ALU operands;  Operation out OL  ALU opcode
//   ex_valid      out  1   EX holds a live instruction
//   ex_rd out RAW; ex_reg_write/ex_mem_read/ex_mem_write out 1; ex_store_data out DW
// BEHAVIOUR
//   - Reset (async, rst_n=0): ex_valid=0, all control bits 0, data/index regs 0 -> SrcA=SrcB=0, Operation=4'b0000, dec_ready=0 during reset.
//   - advance = !ex_valid | ex_ready; dec_ready = advance & !hazard_stall & rst_n.
//   - On edge: flush -> ex_valid<=0, ctrl bits<=0 (highest priority, overrides accept and hold);
//     else dec_valid&dec_ready -> capture all dec_* fields, ex_valid<=1;
//     else advance -> ex_valid<=0, ctrl bits<=0 (bubble); else hold everything.
//   - Latency: accepted instruction drives SrcA/SrcB/Operation the following cycle; forwarding muxes are combinational.
//   - Load-use: hazard_stall=1 when ex_valid & ex_mem_read & ex_rd!=0 & (ex_rd==dec_rs1 | ex_rd==dec_rs2).
//   - x0 (index 0) is never forwarded nor treated as a hazard.
//   - Operation is passed through unchanged; ALU codes AND 0000, OR 0001, ADD 0010, EQ 1000; other codes yield ALU result 0.
//   - No arithmetic here; widths are pass-through, imm already extended by decode.
// CONFIGURATION
//   ID_EX_FWD_EN defined: fwd(r,v): mem_reg_write&mem_rd!=0&mem_rd==r -> mem_result; else same for wb -> wb_result; else v.
//     MEM beats WB. SrcA=fwd(rs1); rs2f=fwd(rs2); SrcB=alu_src?imm:rs2f; ex_store_data=rs2f. Only load-use stalls.
//   ID_EX_FWD_EN undefined: no muxes, SrcA=rs1, SrcB=alu_src?imm:rs2, store=rs2;
//     hazard_stall additionally asserts when dec_rs1/rs2 (non-zero) matches ex_rd(ex_valid&ex_reg_write), mem_rd(mem_reg_write) or wb_rd(wb_reg_write).
// STRUCTURE
//   Package riscv_pipe_pkg: alu_op constants (ALU_AND/OR/ADD/EQ), DATA_WIDTH/REG_ADDR_W localparams, id_ex_ctrl_t struct (reg_write, mem_read, mem_write, alu_src, alu_op).
//   Sub-module fwd_mux (one operand select, priority MEM>WB>reg), instantiated twice under ID_EX_FWD_EN.
// TESTING
//   1. Reset pulse mid-op (ex_valid=1, SrcA=5) -> same cycle, no edge: ex_valid=0, SrcA=SrcB=0, Operation=0000.
//   2. ADD rs1=5 rs2=7 alu_src=0, ex_ready=1 -> next cycle SrcA=5, SrcB=7, Operation=0010, ex_valid=1.
//   3. [FWD_EN] EX rs1=x1; mem_rd=1 mem_result=0x10, wb_rd=1 wb_result=0x20 -> SrcA=0x10; mem_rd=0 -> SrcA=0x20; rd=x0 -> raw value.
//   4. EX lw x5; decode add x6,x5,x1 -> dec_ready=0 one cycle, ex_valid=0 bubble, then accepted.
//   5. ex_ready=0 for 2 cycles -> EX regs/outputs held, dec_ready=0; flush in 2nd cycle -> ex_valid=0 next edge.
//   6. alu_src=1 imm=0xFFFFFFFC rs2=0x55 mem_write=1 -> SrcB=0xFFFFFFFC, ex_store_data=0x55.

Source files
------------

// File: rtl/riscv_pipe_pkg.sv
// riscv_pipe_pkg: shared pipeline types and constants for the RV32 core.
//   ALU_* : ALU operation codes passed through the ID/EX stage unchanged
//   id_ex_ctrl_t : control bundle registered in the ID/EX stage
package riscv_pipe_pkg;

    localparam int DATA_WIDTH    = 32;
    localparam int REG_ADDR_W    = 5;
    localparam int OPCODE_LENGTH = 4;

    localparam logic [OPCODE_LENGTH-1:0] ALU_AND = 4'b0000;
    localparam logic [OPCODE_LENGTH-1:0] ALU_OR  = 4'b0001;
    localparam logic [OPCODE_LENGTH-1:0] ALU_ADD = 4'b0010;
    localparam logic [OPCODE_LENGTH-1:0] ALU_EQ  = 4'b1000;

    typedef struct packed {
        logic                     reg_write;
        logic                     mem_read;
        logic                     mem_write;
        logic                     alu_src;
        logic [OPCODE_LENGTH-1:0] alu_op;
    } id_ex_ctrl_t;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// fwd_mux: selects one operand value, preferring the MEM-stage writer, then
// the WB-stage writer, then the value read from the register file.
// Register x0 is never forwarded.
//   r            : source register index of the operand
//   v            : register-file value of the operand
//   mem_reg_write/mem_rd/mem_result : MEM-stage writer
//   wb_reg_write/wb_rd/wb_result    : WB-stage writer
//   y            : selected operand value
module fwd_mux #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] r,
    input  logic [DATA_WIDTH-1:0] v,
    input  logic                  mem_reg_write,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic [DATA_WIDTH-1:0] mem_result,
    input  logic                  wb_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [DATA_WIDTH-1:0] wb_result,
    output logic [DATA_WIDTH-1:0] y
);

    always_comb begin
        y = v;
        if (mem_reg_write && (mem_rd != '0) && (mem_rd == r))
            y = mem_result;
        else if (wb_reg_write && (wb_rd != '0) && (wb_rd == r))
            y = wb_result;
    end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register of the RV32 core. Captures one decoded
// instruction and drives the ALU operands/opcode plus EX/MEM control.
//   clk, rst_n (async, active-low)
//   dec_*      : decode-side instruction and valid/ready handshake
//   flush      : kills the EX contents (taken branch)
//   ex_ready   : back-pressure from the EX/MEM register
//   mem_*/wb_* : downstream register writers (forwarding / hazard detection)
//   SrcA/SrcB/Operation : ALU inputs; ex_* : EX-stage outputs
// Build option: ID_EX_FWD_EN defined -> operand forwarding from MEM/WB, only
// load-use stalls; undefined -> no forwarding, stall on any pending writer.
module id_ex_stage import riscv_pipe_pkg::*; #(
    parameter int DATA_WIDTH    = riscv_pipe_pkg::DATA_WIDTH,
    parameter int OPCODE_LENGTH = riscv_pipe_pkg::OPCODE_LENGTH,
    parameter int REG_ADDR_W    = riscv_pipe_pkg::REG_ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     dec_valid,
    output logic                     dec_ready,
    input  logic [DATA_WIDTH-1:0]    dec_rs1_data,
    input  logic [DATA_WIDTH-1:0]    dec_rs2_data,
    input  logic [DATA_WIDTH-1:0]    dec_imm,
    input  logic [REG_ADDR_W-1:0]    dec_rs1,
    input  logic [REG_ADDR_W-1:0]    dec_rs2,
    input  logic [REG_ADDR_W-1:0]    dec_rd,
    input  logic [OPCODE_LENGTH-1:0] dec_alu_op,
    input  logic                     dec_alu_src,
    input  logic                     dec_reg_write,
    input  logic                     dec_mem_read,
    input  logic                     dec_mem_write,
    input  logic                     flush,
    input  logic                     ex_ready,
    input  logic                     mem_reg_write,
    input  logic [REG_ADDR_W-1:0]    mem_rd,
    input  logic [DATA_WIDTH-1:0]    mem_result,
    input  logic                     wb_reg_write,
    input  logic [REG_ADDR_W-1:0]    wb_rd,
    input  logic [DATA_WIDTH-1:0]    wb_result,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     ex_valid,
    output logic [REG_ADDR_W-1:0]    ex_rd,
    output logic                     ex_reg_write,
    output logic                     ex_mem_read,
    output logic                     ex_mem_write,
    output logic [DATA_WIDTH-1:0]    ex_store_data
);

    id_ex_ctrl_t           ex_ctrl;
    logic [DATA_WIDTH-1:0] ex_rs1_data;
    logic [DATA_WIDTH-1:0] ex_rs2_data;
    logic [DATA_WIDTH-1:0] ex_imm;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic                  advance;
    logic                  hazard_stall;

    assign advance   = !ex_valid || ex_ready;
    assign dec_ready = advance && !hazard_stall && rst_n;

    always_comb begin
        hazard_stall = 1'b0;
        // Load-use: the loaded value is not available yet, even with forwarding.
        if (ex_valid && ex_ctrl.mem_read && (ex_rd != '0) &&
            ((ex_rd == dec_rs1) || (ex_rd == dec_rs2)))
            hazard_stall = 1'b1;
`ifndef ID_EX_FWD_EN
        // Without forwarding every in-flight writer of a source register stalls.
        if ((dec_rs1 != '0) &&
            ((ex_valid && ex_ctrl.reg_write && (ex_rd == dec_rs1)) ||
             (mem_reg_write && (mem_rd == dec_rs1)) ||
             (wb_reg_write && (wb_rd == dec_rs1))))
            hazard_stall = 1'b1;
        if ((dec_rs2 != '0) &&
            ((ex_valid && ex_ctrl.reg_write && (ex_rd == dec_rs2)) ||
             (mem_reg_write && (mem_rd == dec_rs2)) ||
             (wb_reg_write && (wb_rd == dec_rs2))))
            hazard_stall = 1'b1;
`endif
    end

`ifdef ID_EX_FWD_EN
    logic [REG_ADDR_W-1:0] ex_rs1;
    logic [REG_ADDR_W-1:0] ex_rs2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_rs1 <= '0;
            ex_rs2 <= '0;
        end else if (!flush && dec_valid && dec_ready) begin
            ex_rs1 <= dec_rs1;
            ex_rs2 <= dec_rs2;
        end
    end

    fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
        .r(ex_rs1), .v(ex_rs1_data),
        .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
        .y(op_a)
    );

    fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
        .r(ex_rs2), .v(ex_rs2_data),
        .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
        .y(op_b)
    );
`else
    assign op_a = ex_rs1_data;
    assign op_b = ex_rs2_data;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid    <= 1'b0;
            ex_ctrl     <= '0;
            ex_rd       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
        end else if (flush) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
        end else if (dec_valid && dec_ready) begin
            ex_valid          <= 1'b1;
            ex_ctrl.reg_write <= dec_reg_write;
            ex_ctrl.mem_read  <= dec_mem_read;
            ex_ctrl.mem_write <= dec_mem_write;
            ex_ctrl.alu_src   <= dec_alu_src;
            ex_ctrl.alu_op    <= dec_alu_op;
            ex_rd             <= dec_rd;
            ex_rs1_data       <= dec_rs1_data;
            ex_rs2_data       <= dec_rs2_data;
            ex_imm            <= dec_imm;
        end else if (advance) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
        end
    end

    assign SrcA          = op_a;
    assign SrcB          = ex_ctrl.alu_src ? ex_imm : op_b;
    assign ex_store_data = op_b;
    assign Operation     = ex_ctrl.alu_op;
    assign ex_reg_write  = ex_ctrl.reg_write;
    assign ex_mem_read   = ex_ctrl.mem_read;
    assign ex_mem_write  = ex_ctrl.mem_write;

endmodule
